// File: rtl/l0i_pkg.sv
// l0i_pkg: shared definitions for the L0 instruction line buffer.
//   - FSM state encoding
//   - address-split constants (word offset, line offset) and width helpers
//   - memory message structs (32-bit fetch side, 256-bit line side) and
//     memory message type codes
//   - word_sel(): extracts one 32-bit word from a 256-bit line
package l0i_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TC    = 3'd1,
    ST_MREQ  = 3'd2,
    ST_MWAIT = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = 256;
  localparam int WORD_OFF_W  = 3;   // addr[4:2] selects one of 8 words
  localparam int LINE_OFF_W  = 5;   // addr[4:0] is the byte offset in a line
  localparam int OPAQUE_W    = 8;
  localparam int TYPE_W      = 3;

  localparam logic [TYPE_W-1:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [TYPE_W-1:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [TYPE_W-1:0] MEM_TYPE_INIT  = 3'd2;

  // Fields listed MSB to LSB: type, opaque, addr, len, data.
  typedef struct packed {
    logic [TYPE_W-1:0]   typ;
    logic [OPAQUE_W-1:0] opaque;
    logic [ADDR_W-1:0]   addr;
    logic [1:0]          len;
    logic [WORD_W-1:0]   data;
  } mem_req_32_t;

  typedef struct packed {
    logic [TYPE_W-1:0]   typ;
    logic [OPAQUE_W-1:0] opaque;
    logic [1:0]          test;
    logic [1:0]          len;
    logic [WORD_W-1:0]   data;
  } mem_resp_32_t;

  typedef struct packed {
    logic [TYPE_W-1:0]   typ;
    logic [OPAQUE_W-1:0] opaque;
    logic [ADDR_W-1:0]   addr;
    logic [4:0]          len;
    logic [LINE_W-1:0]   data;
  } mem_req_256_t;

  typedef struct packed {
    logic [TYPE_W-1:0]   typ;
    logic [OPAQUE_W-1:0] opaque;
    logic [1:0]          test;
    logic [4:0]          len;
    logic [LINE_W-1:0]   data;
  } mem_resp_256_t;

  function automatic int idx_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_width(input int num_lines);
    return ADDR_W - LINE_OFF_W - $clog2(num_lines);
  endfunction

  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [WORD_OFF_W-1:0] off);
    return line[{off, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/l0i_line_array.sv
// l0i_line_array: valid/tag/data storage for the L0 instruction buffer.
//   clk, reset      clock, synchronous active-high reset (clears valid bits)
//   rd_idx          combinational read index
//   rd_valid/tag/data  contents of the indexed entry
//   wr_en, wr_idx, wr_tag, wr_data  synchronous allocate: writes tag+data
//                   and sets the valid bit of the indexed entry
//   inval_all       clears every valid bit at the next edge
module l0i_line_array #(
  parameter int NUM_LINES = 2,
  parameter int IDX_W     = 1,
  parameter int TAG_W     = 26,
  parameter int LINE_W    = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              inval_all
);

  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] line_sel;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  // One-hot decode of the allocate target.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_sel
      assign line_sel[gi] = wr_en && (wr_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || inval_all) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_reg | line_sel;
    end
  end

  // Tag and data are deliberately not reset; the valid bit guards them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/l0i_line_buffer.sv
// l0i_line_buffer: direct-mapped L0 instruction buffer between a 32-bit
// fetch port and a 256-bit line memory port.
//   clk, reset                         clock, synchronous active-high reset
//   L0_disable                         bypass: always fetch from memory, never allocate
//   procreq_val/rdy/msg                fetch request (mem_req_32_t)
//   procresp_val/rdy/msg               fetch response (mem_resp_32_t)
//   memreq_val/rdy/msg                 line request (mem_req_256_t)
//   memresp_val/rdy/msg                line response (mem_resp_256_t)
// One request is handled at a time: IDLE -> TC -> (RESP | MREQ -> MWAIT -> RESP).
module l0i_line_buffer
  import l0i_pkg::*;
#(
  parameter int p_num_lines  = 2,
  parameter int p_line_nbits = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          L0_disable,
  input  logic          procreq_val,
  output logic          procreq_rdy,
  input  mem_req_32_t   procreq_msg,
  output logic          procresp_val,
  input  logic          procresp_rdy,
  output mem_resp_32_t  procresp_msg,
  output logic          memreq_val,
  input  logic          memreq_rdy,
  output mem_req_256_t  memreq_msg,
  input  logic          memresp_val,
  output logic          memresp_rdy,
  input  mem_resp_256_t memresp_msg
);

  localparam int IDX_W = idx_width(p_num_lines);
  localparam int TAG_W = tag_width(p_num_lines);

  state_e state_reg, state_next;

  logic [TYPE_W-1:0]   req_typ_reg;
  logic [OPAQUE_W-1:0] req_opaque_reg;
  logic [ADDR_W-1:2]   req_addr_reg;
  logic [WORD_W-1:0]   resp_data_reg;

  logic [WORD_OFF_W-1:0] req_off;
  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;

  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [p_line_nbits-1:0] rd_data;
  logic                    hit;
  logic                    is_read;
  logic                    wr_en;
  logic                    inval_all;

  assign req_off = req_addr_reg[4:2];
  assign req_idx = req_addr_reg[LINE_OFF_W+IDX_W-1:LINE_OFF_W];
  assign req_tag = req_addr_reg[ADDR_W-1:LINE_OFF_W+IDX_W];

  // A hit needs both the valid bit and a full tag match.
  assign hit     = rd_valid && (rd_tag == req_tag);
  assign is_read = (req_typ_reg == MEM_TYPE_READ);

  // Any non-read request flushes the whole buffer so later fetches never
  // see stale instructions.
  assign inval_all = (state_reg == ST_TC) && !is_read;
  assign wr_en     = (state_reg == ST_MWAIT) && memresp_val && !L0_disable;

  l0i_line_array #(
    .NUM_LINES (p_num_lines),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (p_line_nbits)
  ) u_line_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (req_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_idx    (req_idx),
    .wr_tag    (req_tag),
    .wr_data   (memresp_msg.data),
    .inval_all (inval_all)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (procreq_val) state_next = ST_TC;
      ST_TC: begin
        if (!is_read || (hit && !L0_disable)) state_next = ST_RESP;
        else                                  state_next = ST_MREQ;
      end
      ST_MREQ:  if (memreq_rdy)   state_next = ST_MWAIT;
      ST_MWAIT: if (memresp_val)  state_next = ST_RESP;
      ST_RESP:  if (procresp_rdy) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Request latch and response word register. No reset: these are only
  // observed in states reached after they have been loaded.
  always_ff @(posedge clk) begin
    if (state_reg == ST_IDLE && procreq_val) begin
      req_typ_reg    <= procreq_msg.typ;
      req_opaque_reg <= procreq_msg.opaque;
      req_addr_reg   <= procreq_msg.addr[ADDR_W-1:2];
    end
    if (state_reg == ST_TC) begin
      // On a miss this value is overwritten in MWAIT.
      resp_data_reg <= is_read ? word_sel(rd_data, req_off) : '0;
    end
    if (state_reg == ST_MWAIT && memresp_val) begin
      resp_data_reg <= word_sel(memresp_msg.data, req_off);
    end
  end

  // Outputs depend only on state and registers, never on same-cycle rdy.
  always_comb begin
    procreq_rdy  = (state_reg == ST_IDLE);
    memreq_val   = (state_reg == ST_MREQ);
    memresp_rdy  = (state_reg == ST_MWAIT);
    procresp_val = (state_reg == ST_RESP);

    memreq_msg        = '0;
    memreq_msg.typ    = MEM_TYPE_READ;
    memreq_msg.addr   = {req_addr_reg[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};

    procresp_msg        = '0;
    procresp_msg.typ    = req_typ_reg;
    procresp_msg.opaque = req_opaque_reg;
    procresp_msg.data   = resp_data_reg;
  end

  // Message fields this block never needs.
  logic unused_bits;
  assign unused_bits = ^{procreq_msg.len, procreq_msg.data, procreq_msg.addr[1:0],
                         memresp_msg.typ, memresp_msg.opaque, memresp_msg.test,
                         memresp_msg.len};

endmodule

// File: tb/tb_l0i_line_buffer.sv
// Directed bench for l0i_line_buffer with a one-line-per-request memory model.
module tb_l0i_line_buffer;
  import l0i_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          L0_disable;
  logic          procreq_val;
  logic          procreq_rdy;
  mem_req_32_t   procreq_msg;
  logic          procresp_val;
  logic          procresp_rdy;
  mem_resp_32_t  procresp_msg;
  logic          memreq_val;
  logic          memreq_rdy;
  mem_req_256_t  memreq_msg;
  logic          memresp_val;
  logic          memresp_rdy;
  mem_resp_256_t memresp_msg;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  l0i_line_buffer #(.p_num_lines(2), .p_line_nbits(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .L0_disable   (L0_disable),
    .procreq_val  (procreq_val),
    .procreq_rdy  (procreq_rdy),
    .procreq_msg  (procreq_msg),
    .procresp_val (procresp_val),
    .procresp_rdy (procresp_rdy),
    .procresp_msg (procresp_msg),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memreq_msg   (memreq_msg),
    .memresp_val  (memresp_val),
    .memresp_rdy  (memresp_rdy),
    .memresp_msg  (memresp_msg)
  );

  // ---------------- memory model ----------------
  // Word k of the line at address A holds A - 0x100 + k
  // (so line 0x200 holds 0x100..0x107, line 0x240 holds 0x140..0x147).
  function automatic logic [255:0] mk_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = a - 32'h100 + 32'(k);
    return l;
  endfunction

  int          memreq_count = 0;
  logic [31:0] last_addr;
  logic [2:0]  last_type;
  logic [4:0]  last_len;
  logic        pend;
  logic [31:0] pend_addr;
  logic        mem_hold;

  always @(posedge clk) begin
    if (reset) begin
      pend        <= 1'b0;
      memresp_val <= 1'b0;
    end else begin
      if (memresp_val && memresp_rdy) begin
        memresp_val <= 1'b0;
      end else if (pend && !mem_hold && !memresp_val) begin
        memresp_val      <= 1'b1;
        memresp_msg      <= '0;
        memresp_msg.data <= mk_line(pend_addr);
        pend             <= 1'b0;
      end
      if (memreq_val && memreq_rdy) begin
        memreq_count <= memreq_count + 1;
        last_addr    <= memreq_msg.addr;
        last_type    <= memreq_msg.typ;
        last_len     <= memreq_msg.len;
        pend         <= 1'b1;
        pend_addr    <= memreq_msg.addr;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Issues one request, waits (bounded) for the response, lets it fire.
  task automatic fetch(input logic [31:0] a, input logic [7:0] opq, input logic [2:0] typ,
                       output mem_resp_32_t r, output int lat, output int nreq);
    int c0;
    c0 = memreq_count;
    @(negedge clk);
    procreq_val      = 1'b1;
    procreq_msg      = '0;
    procreq_msg.typ  = typ;
    procreq_msg.opaque = opq;
    procreq_msg.addr = a;
    procreq_msg.data = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    procreq_val = 1'b0;
    lat = 0;
    while (!procresp_val && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = procresp_msg;
    procresp_rdy = 1'b1;
    @(posedge clk);
    #1;
    nreq = memreq_count - c0;
    $display("fetch type=%0d addr=0x%08h opaque=0x%02h -> type=%0d opaque=0x%02h data=0x%08h lat=%0d memreqs=%0d",
             typ, a, opq, r.typ, r.opaque, r.data, lat, nreq);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  mem_resp_32_t r, snap;
  int lat, nreq, c0, w;

  initial begin
    reset        = 1'b1;
    L0_disable   = 1'b0;
    procreq_val  = 1'b0;
    procreq_msg  = '0;
    procresp_rdy = 1'b1;
    memreq_rdy   = 1'b1;
    mem_hold     = 1'b0;
    memresp_msg  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_procreq_rdy",  procreq_rdy,  1'b1);
    check("rst_procresp_val", procresp_val, 1'b0);
    check("rst_memreq_val",   memreq_val,   1'b0);
    check("rst_memresp_rdy",  memresp_rdy,  1'b0);

    // Cold miss
    fetch(32'h0000_0204, 8'h11, MEM_TYPE_READ, r, lat, nreq);
    check("cold_timeout", lat < 100, 1'b1);
    check("cold_nreq",    nreq, 1);
    check("cold_addr",    last_addr, 32'h200);
    check("cold_mtype",   last_type, 3'd0);
    check("cold_mlen",    last_len, 5'd0);
    check("cold_data",    r.data, 32'h101);
    check("cold_opaque",  r.opaque, 8'h11);
    check("cold_type",    r.typ, 3'd0);

    // Hit after fill
    fetch(32'h0000_021C, 8'h22, MEM_TYPE_READ, r, lat, nreq);
    check("hit_nreq",   nreq, 0);
    check("hit_data",   r.data, 32'h107);
    check("hit_lat",    lat, 1);
    check("hit_opaque", r.opaque, 8'h22);

    // Conflict on index 0
    do_reset();
    c0 = memreq_count;
    fetch(32'h0000_0200, 8'h01, MEM_TYPE_READ, r, lat, nreq);
    check("conf_d0", r.data, 32'h100);
    fetch(32'h0000_0240, 8'h02, MEM_TYPE_READ, r, lat, nreq);
    check("conf_d1", r.data, 32'h140);
    check("conf_a1", last_addr, 32'h240);
    fetch(32'h0000_0200, 8'h03, MEM_TYPE_READ, r, lat, nreq);
    check("conf_d2", r.data, 32'h100);
    check("conf_total", memreq_count - c0, 3);

    // Disable: no allocation while bypassed
    do_reset();
    L0_disable = 1'b1;
    c0 = memreq_count;
    fetch(32'h0000_0204, 8'h04, MEM_TYPE_READ, r, lat, nreq);
    check("dis_d0", r.data, 32'h101);
    fetch(32'h0000_0204, 8'h05, MEM_TYPE_READ, r, lat, nreq);
    check("dis_d1", r.data, 32'h101);
    check("dis_nreq", memreq_count - c0, 2);
    L0_disable = 1'b0;
    fetch(32'h0000_0204, 8'h06, MEM_TYPE_READ, r, lat, nreq);
    check("reen_miss", nreq, 1);
    fetch(32'h0000_0208, 8'h07, MEM_TYPE_READ, r, lat, nreq);
    check("reen_hit",  nreq, 0);
    check("reen_data", r.data, 32'h102);

    // Flush by write-type request
    fetch(32'h0000_0200, 8'h08, MEM_TYPE_WRITE, r, lat, nreq);
    check("flush_type",   r.typ, 3'd1);
    check("flush_data",   r.data, 32'h0);
    check("flush_opaque", r.opaque, 8'h08);
    check("flush_nreq",   nreq, 0);
    fetch(32'h0000_0200, 8'h09, MEM_TYPE_READ, r, lat, nreq);
    check("flush_miss",   nreq, 1);
    check("flush_rdata",  r.data, 32'h100);

    // Backpressure on a hit
    @(negedge clk);
    procresp_rdy     = 1'b0;
    procreq_val      = 1'b1;
    procreq_msg      = '0;
    procreq_msg.addr = 32'h0000_0204;
    procreq_msg.opaque = 8'h0A;
    @(posedge clk);
    @(negedge clk);
    procreq_val = 1'b0;
    w = 0;
    while (!procresp_val && w < 20) begin
      @(negedge clk);
      w++;
    end
    snap = procresp_msg;
    check("bp_data", snap.data, 32'h101);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_val", procresp_val, 1'b1);
      check("bp_msg", procresp_msg, snap);
    end
    $display("backpressure held 5 cycles data=0x%08h", procresp_msg.data);
    procresp_rdy = 1'b1;
    @(posedge clk);
    #1;

    // Reset while waiting for memory
    mem_hold = 1'b1;
    @(negedge clk);
    procreq_val      = 1'b1;
    procreq_msg      = '0;
    procreq_msg.addr = 32'h0000_0240;
    @(posedge clk);
    @(negedge clk);
    procreq_val = 1'b0;
    w = 0;
    while (!memresp_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("mw_reached", memresp_rdy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_procreq_rdy",  procreq_rdy,  1'b1);
    check("mrst_procresp_val", procresp_val, 1'b0);
    check("mrst_memreq_val",   memreq_val,   1'b0);
    check("mrst_memresp_rdy",  memresp_rdy,  1'b0);
    $display("reset in MWAIT: outputs back to reset values");
    reset    = 1'b0;
    mem_hold = 1'b0;
    fetch(32'h0000_0204, 8'h0B, MEM_TYPE_READ, r, lat, nreq);
    check("mrst_miss", nreq, 1);
    check("mrst_data", r.data, 32'h101);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
